// File: rtl/uart_rx_engine.sv
// UART receiver: 2-flop synchronized rx, mid-bit sampling, optional even
// parity, framing check with break hold-off, selectable baud divisor.
module uart_rx_engine #(
  parameter int DATA_BITS = 8,
  parameter bit PARITY_EN = 1'b1
) (
  input  logic                 clk_in,
  input  logic                 rst,
  input  logic                 rx,
  input  logic                 s0,
  input  logic                 s1,
  output logic [DATA_BITS-1:0] dout,
  output logic                 done,
  output logic                 err,
  output logic                 busy
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;
  localparam logic [2:0] BREAK  = 3'd5;

  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

  logic                 rx_m_q, rx_s_q;
  logic [2:0]           state_q, state_d;
  logic [7:0]           cnt_q, cnt_d;
  logic [1:0]           sel_q, sel_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [DATA_BITS-1:0] sh_q, sh_d;
  logic                 perr_q, perr_d;
  logic [DATA_BITS-1:0] dout_q, dout_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;

  logic [7:0] full_m1;
  logic [7:0] half_m1;
  logic       tick;

  // Full-bit reload uses the latched select; half-bit uses the live one.
  always_comb begin
    full_m1 = 8'd207;
    case (sel_q)
      2'b00:   full_m1 = 8'd207;
      2'b01:   full_m1 = 8'd103;
      2'b10:   full_m1 = 8'd51;
      default: full_m1 = 8'd25;
    endcase
    half_m1 = 8'd103;
    case ({s1, s0})
      2'b00:   half_m1 = 8'd103;
      2'b01:   half_m1 = 8'd51;
      2'b10:   half_m1 = 8'd25;
      default: half_m1 = 8'd12;
    endcase
  end

  assign tick = (cnt_q == 8'd0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    perr_d  = perr_q;
    dout_d  = dout_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (!rx_s_q) begin
          state_d = START;
          sel_d   = {s1, s0};
          cnt_d   = half_m1;
          bit_d   = '0;
          perr_d  = 1'b0;
        end
      end
      START: begin
        if (!tick) begin
          cnt_d = cnt_q - 8'd1;
        end else if (!rx_s_q) begin
          state_d = DATA;
          cnt_d   = full_m1;
        end else begin
          state_d = IDLE;
        end
      end
      DATA: begin
        if (!tick) begin
          cnt_d = cnt_q - 8'd1;
        end else begin
          sh_d = sh_q >> 1;
          sh_d[DATA_BITS-1] = rx_s_q;
          cnt_d = full_m1;
          if (bit_q == LAST_BIT) begin
            bit_d   = '0;
            state_d = PARITY_EN ? PARITY : STOP;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      PARITY: begin
        if (!tick) begin
          cnt_d = cnt_q - 8'd1;
        end else begin
          perr_d  = (^sh_q) ^ rx_s_q;
          cnt_d   = full_m1;
          state_d = STOP;
        end
      end
      STOP: begin
        if (!tick) begin
          cnt_d = cnt_q - 8'd1;
        end else begin
          done_d  = 1'b1;
          dout_d  = sh_q;
          err_d   = perr_q | ~rx_s_q;
          cnt_d   = 8'd0;
          state_d = rx_s_q ? IDLE : BREAK;
        end
      end
      BREAK: begin
        // Hold off until the line returns high so a stuck-low line
        // yields a single errored frame.
        if (rx_s_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      rx_m_q  <= 1'b1;
      rx_s_q  <= 1'b1;
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      sel_q   <= 2'b00;
      bit_q   <= '0;
      sh_q    <= '0;
      perr_q  <= 1'b0;
      dout_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      rx_m_q  <= rx;
      rx_s_q  <= rx_m_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      perr_q  <= perr_d;
      dout_q  <= dout_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign dout = dout_q;
  assign done = done_q;
  assign err  = err_q;
  assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_engine.sv
// Directed bench for uart_rx_engine: good/errored frames, glitch,
// baud latching, mid-frame reset and back-to-back frames.
module tb_uart_rx_engine;

  logic       clk_in = 1'b0;
  logic       rst = 1'b1;
  logic       rx = 1'b1;
  logic       s0 = 1'b1;
  logic       s1 = 1'b1;
  logic [7:0] dout;
  logic       done;
  logic       err;
  logic       busy;

  int checks = 0;
  int errors = 0;

  int         cyc = 0;
  int         ndone = 0;
  logic [7:0] rec_dout [0:63];
  logic       rec_err  [0:63];
  int         rec_cyc  [0:63];

  uart_rx_engine #(.DATA_BITS(8), .PARITY_EN(1'b1)) dut (
    .clk_in(clk_in),
    .rst(rst),
    .rx(rx),
    .s0(s0),
    .s1(s1),
    .dout(dout),
    .done(done),
    .err(err),
    .busy(busy)
  );

  always #5 clk_in = ~clk_in;

  always @(posedge clk_in) cyc <= cyc + 1;

  always @(negedge clk_in) begin
    if (done && ndone < 64) begin
      rec_dout[ndone] <= dout;
      rec_err[ndone]  <= err;
      rec_cyc[ndone]  <= cyc;
      ndone <= ndone + 1;
    end
  end

  task automatic hold(input logic v, input int n);
    rx = v;
    repeat (n) @(negedge clk_in);
  endtask

  // Frame: start, 8 data LSB first, parity, stop. Optional select
  // change at the start of data bit chg_bit.
  task automatic send_frame(input logic [7:0] d, input logic p,
                            input logic stp, input int n,
                            input int chg_bit, input logic [1:0] nsel);
    hold(1'b0, n);
    for (int i = 0; i < 8; i++) begin
      if (i == chg_bit) {s1, s0} = nsel;
      hold(d[i], n);
    end
    hold(p, n);
    hold(stp, n);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk_in);
    checks++;
    if (dout !== 8'h00) begin
      errors++;
      $display("FAIL reset_dout: got %h want 00", dout);
    end
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL reset_done: got %b want 0", done);
    end
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL reset_err: got %b want 0", err);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_busy: got %b want 0", busy);
    end
    rst = 1'b0;
    repeat (3) @(negedge clk_in);
  endtask

  task automatic test_good_frame;
    int base, t0, lat;
    {s1, s0} = 2'b11;
    base = ndone;
    t0 = cyc;
    send_frame(8'hA5, 1'b0, 1'b1, 26, -1, 2'b00);
    hold(1'b1, 10);
    checks++;
    if (ndone - base !== 1) begin
      errors++;
      $display("FAIL good_count: got %0d want 1", ndone - base);
    end else begin
      checks++;
      if (rec_dout[base] !== 8'hA5) begin
        errors++;
        $display("FAIL good_dout: got %h want a5", rec_dout[base]);
      end
      checks++;
      if (rec_err[base] !== 1'b0) begin
        errors++;
        $display("FAIL good_err: got %b want 0", rec_err[base]);
      end
      lat = rec_cyc[base] - t0;
      checks++;
      if (lat < 271 || lat > 278) begin
        errors++;
        $display("FAIL good_latency: got %0d want 271..278", lat);
      end
    end
  endtask

  task automatic test_parity_err;
    int base;
    {s1, s0} = 2'b00;
    base = ndone;
    send_frame(8'h01, 1'b0, 1'b1, 208, -1, 2'b00);
    hold(1'b1, 20);
    checks++;
    if (ndone - base !== 1) begin
      errors++;
      $display("FAIL par_count: got %0d want 1", ndone - base);
    end else begin
      checks++;
      if (rec_err[base] !== 1'b1) begin
        errors++;
        $display("FAIL par_err: got %b want 1", rec_err[base]);
      end
      checks++;
      if (rec_dout[base] !== 8'h01) begin
        errors++;
        $display("FAIL par_dout: got %h want 01", rec_dout[base]);
      end
    end
  endtask

  task automatic test_framing;
    int base;
    {s1, s0} = 2'b11;
    base = ndone;
    send_frame(8'h12, 1'b0, 1'b0, 26, -1, 2'b00);
    hold(1'b0, 78);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL brk_busy: got %b want 1", busy);
    end
    hold(1'b1, 52);
    send_frame(8'h3C, 1'b0, 1'b1, 26, -1, 2'b00);
    hold(1'b1, 10);
    checks++;
    if (ndone - base !== 2) begin
      errors++;
      $display("FAIL brk_count: got %0d want 2", ndone - base);
    end else begin
      checks++;
      if (rec_err[base] !== 1'b1) begin
        errors++;
        $display("FAIL brk_err1: got %b want 1", rec_err[base]);
      end
      checks++;
      if (rec_err[base+1] !== 1'b0) begin
        errors++;
        $display("FAIL brk_err2: got %b want 0", rec_err[base+1]);
      end
      checks++;
      if (rec_dout[base+1] !== 8'h3C) begin
        errors++;
        $display("FAIL brk_dout2: got %h want 3c", rec_dout[base+1]);
      end
    end
  endtask

  task automatic test_glitch;
    int base, rise, fall;
    {s1, s0} = 2'b00;
    base = ndone;
    rise = -1;
    fall = -1;
    rx = 1'b0;
    for (int i = 0; i < 300 && fall < 0; i++) begin
      @(negedge clk_in);
      if (i == 4) rx = 1'b1;
      if (busy && rise < 0) rise = i;
      if (!busy && rise >= 0) fall = i;
    end
    checks++;
    if (rise < 0 || fall < 0 || fall - rise > 105) begin
      errors++;
      $display("FAIL glitch_busy: rise %0d fall %0d want <=105",
               rise, fall);
    end
    hold(1'b1, 20);
    checks++;
    if (ndone - base !== 0) begin
      errors++;
      $display("FAIL glitch_done: got %0d want 0", ndone - base);
    end
  endtask

  task automatic test_baud_change;
    int base;
    {s1, s0} = 2'b10;
    base = ndone;
    send_frame(8'h5A, 1'b0, 1'b1, 52, 3, 2'b00);
    hold(1'b1, 10);
    send_frame(8'hC3, 1'b0, 1'b1, 208, -1, 2'b00);
    hold(1'b1, 20);
    checks++;
    if (ndone - base !== 2) begin
      errors++;
      $display("FAIL baud_count: got %0d want 2", ndone - base);
    end else begin
      checks++;
      if (rec_dout[base] !== 8'h5A || rec_err[base] !== 1'b0) begin
        errors++;
        $display("FAIL baud_f1: got %h/%b want 5a/0",
                 rec_dout[base], rec_err[base]);
      end
      checks++;
      if (rec_dout[base+1] !== 8'hC3 || rec_err[base+1] !== 1'b0) begin
        errors++;
        $display("FAIL baud_f2: got %h/%b want c3/0",
                 rec_dout[base+1], rec_err[base+1]);
      end
    end
  endtask

  task automatic test_reset_mid;
    int base;
    {s1, s0} = 2'b11;
    base = ndone;
    hold(1'b0, 26);
    hold(1'b1, 78);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_busy_pre: got %b want 1", busy);
    end
    rst = 1'b1;
    repeat (3) @(negedge clk_in);
    rst = 1'b0;
    checks++;
    if (dout !== 8'h00 || busy !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_outs: got %h/%b/%b want 00/0/0",
               dout, busy, err);
    end
    hold(1'b1, 200);
    checks++;
    if (ndone - base !== 0) begin
      errors++;
      $display("FAIL rstmid_done: got %0d want 0", ndone - base);
    end
    base = ndone;
    send_frame(8'h81, 1'b0, 1'b1, 26, -1, 2'b00);
    hold(1'b1, 10);
    checks++;
    if (ndone - base !== 1 || rec_dout[base] !== 8'h81 ||
        rec_err[base] !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_next: count %0d dout %h err %b want 1/81/0",
               ndone - base, rec_dout[base], rec_err[base]);
    end
  endtask

  task automatic test_back_to_back;
    int base;
    {s1, s0} = 2'b11;
    base = ndone;
    send_frame(8'h00, 1'b0, 1'b1, 26, -1, 2'b00);
    send_frame(8'hFF, 1'b0, 1'b1, 26, -1, 2'b00);
    hold(1'b1, 10);
    checks++;
    if (ndone - base !== 2) begin
      errors++;
      $display("FAIL b2b_count: got %0d want 2", ndone - base);
    end else begin
      checks++;
      if (rec_dout[base] !== 8'h00 || rec_dout[base+1] !== 8'hFF) begin
        errors++;
        $display("FAIL b2b_dout: got %h,%h want 00,ff",
                 rec_dout[base], rec_dout[base+1]);
      end
      checks++;
      if (rec_err[base] !== 1'b0 || rec_err[base+1] !== 1'b0) begin
        errors++;
        $display("FAIL b2b_err: got %b,%b want 0,0",
                 rec_err[base], rec_err[base+1]);
      end
    end
    checks++;
    if (dout !== 8'hFF) begin
      errors++;
      $display("FAIL b2b_hold: got %h want ff", dout);
    end
  endtask

  initial begin
    test_reset;
    test_good_frame;
    test_parity_err;
    test_framing;
    test_glitch;
    test_baud_change;
    test_reset_mid;
    test_back_to_back;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
